// File: rtl/alu_arbiter_if.sv
// ----------------------------------------------------------------------------
// alu_arbiter_if
// Bundles every non-clock signal of the shared-ALU arbiter:
//   - two requesters (req_valid/req_ready handshake plus operands and aluOp)
//   - the shared ALU connection (operands out, result and zero flag back in)
//   - the response channel (rsp_valid/rsp_ready handshake, result, zero, err)
//   - busy status
// Modports:
//   slave  : the arbiter's view
//   master : the surrounding environment's view (requesters, ALU, consumer)
// ----------------------------------------------------------------------------
interface alu_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req0_data1;
    logic [WIDTH-1:0] req0_data2;
    logic [OPW-1:0]   req0_aluOp;
    logic [WIDTH-1:0] req1_data1;
    logic [WIDTH-1:0] req1_data2;
    logic [OPW-1:0]   req1_aluOp;
    logic [WIDTH-1:0] alu_data1;
    logic [WIDTH-1:0] alu_data2;
    logic [OPW-1:0]   alu_aluOp;
    logic [WIDTH-1:0] alu_address;
    logic             alu_zero;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [WIDTH-1:0] rsp_address;
    logic             rsp_zero;
    logic             rsp_err;
    logic             busy;

    modport slave (
        input  req_valid,
        output req_ready,
        input  req0_data1, req0_data2, req0_aluOp,
        input  req1_data1, req1_data2, req1_aluOp,
        output alu_data1, alu_data2, alu_aluOp,
        input  alu_address, alu_zero,
        output rsp_valid,
        input  rsp_ready,
        output rsp_address, rsp_zero, rsp_err,
        output busy
    );

    modport master (
        output req_valid,
        input  req_ready,
        output req0_data1, req0_data2, req0_aluOp,
        output req1_data1, req1_data2, req1_aluOp,
        input  alu_data1, alu_data2, alu_aluOp,
        output alu_address, alu_zero,
        input  rsp_valid,
        output rsp_ready,
        input  rsp_address, rsp_zero, rsp_err,
        input  busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// ----------------------------------------------------------------------------
// alu_arbiter
// Shares one external ALU between requester 0 (main datapath) and requester 1
// (branch/address unit). Requests are granted round-robin on a valid/ready
// handshake; the winner's operands are latched and driven to the ALU for one
// cycle, and the ALU result is registered and held on the response channel
// until the owning requester accepts it. Unsupported aluOp codes bypass the
// ALU result and respond with err=1, address=0, zero=1.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : alu_arbiter_if.slave (request, ALU and response channels, busy)
// Operation takes a minimum of three cycles: IDLE (accept), ISSUE, RESP.
// ----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RESP  = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;

    logic             owner_r;
    logic             last_grant_r;
    logic             op_ok_r;
    logic [WIDTH-1:0] data1_r;
    logic [WIDTH-1:0] data2_r;
    logic [OPW-1:0]   aluop_r;
    logic [WIDTH-1:0] rsp_address_r;
    logic             rsp_zero_r;
    logic             rsp_err_r;

    logic             grant_s;
    logic [1:0]       req_ready_s;
    logic             accept_s;
    logic [1:0]       rsp_valid_s;
    logic             rsp_done_s;
    logic [WIDTH-1:0] sel_data1_s;
    logic [WIDTH-1:0] sel_data2_s;
    logic [OPW-1:0]   sel_aluop_s;

    // Opcodes the shared ALU implements: and, or, add, sub, slt, lui.
    function automatic logic op_supported(input logic [OPW-1:0] op);
        logic ok;
        case (op)
            OPW'(3'b000),
            OPW'(3'b001),
            OPW'(3'b010),
            OPW'(3'b110),
            OPW'(3'b111),
            OPW'(3'b011): ok = 1'b1;
            default:      ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Round-robin pick: a lone requester wins; a tie goes to the one not granted last.
    always_comb begin
        grant_s = 1'b0;
        case (bus.req_valid)
            2'b01:   grant_s = 1'b0;
            2'b10:   grant_s = 1'b1;
            2'b11:   grant_s = ~last_grant_r;
            default: grant_s = 1'b0;
        endcase
    end

    // Ready only in IDLE, only to the granted requester, and never while reset is asserted.
    always_comb begin
        req_ready_s = 2'b00;
        if ((state_r == IDLE) && rst_n) begin
            if (grant_s) begin
                req_ready_s = {bus.req_valid[1], 1'b0};
            end else begin
                req_ready_s = {1'b0, bus.req_valid[0]};
            end
        end else begin
            req_ready_s = 2'b00;
        end
    end

    // req_ready already implies the matching req_valid, so any ready bit is an accept.
    assign accept_s = |req_ready_s;

    // Response valid points at the owner; the non-owner's rsp_ready is masked out.
    always_comb begin
        rsp_valid_s = 2'b00;
        if (state_r == RESP) begin
            if (owner_r) begin
                rsp_valid_s = 2'b10;
            end else begin
                rsp_valid_s = 2'b01;
            end
        end else begin
            rsp_valid_s = 2'b00;
        end
    end

    assign rsp_done_s = |(rsp_valid_s & bus.rsp_ready);

    // Operand mux in front of the capture registers.
    always_comb begin
        sel_data1_s = bus.req0_data1;
        sel_data2_s = bus.req0_data2;
        sel_aluop_s = bus.req0_aluOp;
        if (grant_s) begin
            sel_data1_s = bus.req1_data1;
            sel_data2_s = bus.req1_data2;
            sel_aluop_s = bus.req1_aluOp;
        end else begin
            sel_data1_s = bus.req0_data1;
            sel_data2_s = bus.req0_data2;
            sel_aluop_s = bus.req0_aluOp;
        end
    end

    // Next-state logic: IDLE -> ISSUE on accept, ISSUE -> RESP always, RESP -> IDLE on owner handshake.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: state_nxt_s = RESP;
            RESP: begin
                if (rsp_done_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Capture the granted request; these registers also drive the ALU, so the ALU
    // inputs stay put outside ISSUE and requesters may drop operands after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
            op_ok_r      <= 1'b0;
            data1_r      <= {WIDTH{1'b0}};
            data2_r      <= {WIDTH{1'b0}};
            aluop_r      <= OPW'(3'b010);
        end else if (accept_s) begin
            owner_r      <= grant_s;
            last_grant_r <= grant_s;
            op_ok_r      <= op_supported(sel_aluop_s);
            data1_r      <= sel_data1_s;
            data2_r      <= sel_data2_s;
            aluop_r      <= sel_aluop_s;
        end
    end

    // Register the ALU result at the end of ISSUE; an unsupported opcode ignores the ALU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_address_r <= {WIDTH{1'b0}};
            rsp_zero_r    <= 1'b0;
            rsp_err_r     <= 1'b0;
        end else if (state_r == ISSUE) begin
            if (op_ok_r) begin
                rsp_address_r <= bus.alu_address;
                rsp_zero_r    <= bus.alu_zero;
                rsp_err_r     <= 1'b0;
            end else begin
                rsp_address_r <= {WIDTH{1'b0}};
                rsp_zero_r    <= 1'b1;
                rsp_err_r     <= 1'b1;
            end
        end
    end

    assign bus.req_ready   = req_ready_s;
    assign bus.rsp_valid   = rsp_valid_s;
    assign bus.alu_data1   = data1_r;
    assign bus.alu_data2   = data2_r;
    assign bus.alu_aluOp   = aluop_r;
    assign bus.rsp_address = rsp_address_r;
    assign bus.rsp_zero    = rsp_zero_r;
    assign bus.rsp_err     = rsp_err_r;
    assign bus.busy        = (state_r != IDLE);

endmodule
